syslatch_seq: RTL and testbench
===============================

# syslatch_seq

Bus-side sequencer that drives the system latch's bit-write interface. It accepts an 8-bit target latch value and issues one bit-write cycle per bit that must change. Each cycle presents the bit index and value on M68K_ADDR[4:1] and strobes nBITW1. It keeps a mirror of the latch contents, so the rest of the system (boot/test controller, BIOS model) can set SHADOW/nVEC/nCARDWEN/CARDWENB/nREGEN/nSYSTEM/SRAM-write/PALBNK without hand-crafting 68K writes.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles the address is driven with nBITW1 high before the strobe (1..15)
- STROBE_CYCLES, 2, cycles nBITW1 is held low (1..15)
- HOLD_CYCLES, 1, cycles the address is held with nBITW1 high after the strobe (1..15)

Ports:
- CLK_24M  in  1  system clock, all logic on rising edge
- nRESET  in  1  reset, synchronous, active-low
- REQ  in  1  start request, level, sampled only in IDLE
- TARGET  in  8  desired latch value, captured when REQ is accepted
- FORCE  in  1  captured with TARGET; 1 = write all 8 bits regardless of mirror
- BUSY  out  1  high from the first SCAN cycle through DONE inclusive
- ACK  out  1  one-cycle pulse in DONE
- M68K_ADDR  out  4 ([4:1])  [4] = bit value, [3:1] = bit index
- nBITW1  out  1  active-low bit-write strobe
- LATCH_MIRROR  out  8  modelled latch contents

## Operation
- Reset (nRESET low at an edge) sets:
  - state IDLE, LATCH_MIRROR = 8'h00 (the latch also clears on reset)
  - nBITW1 = 1, M68K_ADDR = 4'h0, BUSY = 0, ACK = 0
  - bit index = 0, captured target = 0, FORCE = 0
- Reset has priority over everything, including mid-strobe: nBITW1 returns high at that edge.
- States: IDLE, SCAN, SETUP, STROBE, HOLD, DONE.
- IDLE: if REQ = 1, capture TARGET and FORCE, set index = 0, go to SCAN. Otherwise stay in IDLE.
- SCAN: one cycle per index.
  - If FORCE, or target[index] != mirror[index]: load M68K_ADDR = {target[index], index[2:0]}, go to SETUP.
  - Otherwise: if index = 7 go to DONE, else index+1 and stay in SCAN.
- SETUP: SETUP_CYCLES cycles with nBITW1 = 1, then go to STROBE.
- STROBE: STROBE_CYCLES cycles with nBITW1 = 0. On leaving STROBE, mirror[index] <= target[index]. Then go to HOLD.
- HOLD: HOLD_CYCLES cycles with nBITW1 = 1. Then, if index = 7 go to DONE, else index+1 and go to SCAN.
- DONE: ACK = 1 for one cycle, then go to IDLE.
- Bits are processed in ascending index order, 0 to 7.
- Inputs are ignored outside IDLE: REQ, TARGET and FORCE changes while BUSY have no effect. Requests are not queued.
- If REQ is still high when IDLE is re-entered, a new transaction starts (back-to-back).
- M68K_ADDR keeps its last driven value in IDLE, SCAN and DONE. It changes only on entry to SETUP.
- Phase counter is 4 bits and reloads on each phase entry. Index is 3 bits. No wrap beyond index 7.

## Timing
- All outputs are registered. A REQ sampled at edge k gives SCAN and BUSY = 1 from cycle k+1.
- Let N = bits written and P = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES.
- Transaction length, first SCAN cycle through ACK cycle inclusive: 8 + N·P + 1 cycles.
- With defaults, P = 4 and the worst case (N = 8) is 41 cycles.
- Address setup before the nBITW1 falling edge is ≥ SETUP_CYCLES cycles. Hold after the rising edge is ≥ HOLD_CYCLES cycles.
- Minimum nBITW1-high time between strobes is HOLD_CYCLES + 1 + SETUP_CYCLES.
- LATCH_MIRROR updates on the same edge that nBITW1 rises.
- BUSY falls on the edge after the ACK cycle. ACK and BUSY are both high in DONE.

## Test plan
- Reset → nBITW1 = 1, M68K_ADDR = 0, BUSY = 0, ACK = 0, LATCH_MIRROR = 8'h00.
  - Then assert nRESET low during STROBE: nBITW1 = 1 on that edge and mirror = 0.
- Mirror 8'h00, TARGET = 8'h01, defaults → exactly one 2-cycle nBITW1 pulse with M68K_ADDR = 4'b1000. ACK is 13 cycles after the first SCAN cycle. Mirror = 8'h01.
- Mirror 8'hA5, TARGET = 8'hA5, FORCE = 0 → no strobes, ACK in cycle 9. Same request with FORCE = 1 → 8 strobes with addresses 4'b1000, 4'b0001, 4'b1010, 4'b0011, 4'b0100, 4'b1101, 4'b0110, 4'b1111.
- Mirror 8'h00, TARGET = 8'hFF → 8 strobes in index order 0..7, ACK in cycle 41, BUSY high for all 41 cycles.
  - Toggling REQ and changing TARGET to 8'h00 mid-transaction has no effect.
- Bench couples the outputs to a bit-addressed latch model: after random TARGET/FORCE sequences, including back-to-back REQ held high, the latch model equals LATCH_MIRROR at every ACK.
  - Run with SETUP/STROBE/HOLD = 1/1/1 and 15/15/15.

Source files
------------

// File: rtl/syslatch_seq.sv
// Bit-write sequencer for the system latch: walks a captured target value bit by
// bit and strobes nBITW1 once for each bit that differs from the mirrored latch.
module syslatch_seq #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic       REQ,
  input  logic [7:0] TARGET,
  input  logic       FORCE,
  output logic       BUSY,
  output logic       ACK,
  output logic [4:1] M68K_ADDR,
  output logic       nBITW1,
  output logic [7:0] LATCH_MIRROR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Phase counters load N-1 and the phase ends on the cycle the count reads 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] tgt_q, tgt_d;
  logic       force_q, force_d;
  logic [7:0] mirror_q, mirror_d;
  logic [3:0] addr_q, addr_d;
  logic       nbitw1_q, nbitw1_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tgt_d    = tgt_q;
    force_d  = force_q;
    mirror_d = mirror_q;
    addr_d   = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          tgt_d   = TARGET;
          force_d = FORCE;
          idx_d   = 3'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (force_q || (tgt_q[idx_q] != mirror_q[idx_q])) begin
          addr_d  = {tgt_q[idx_q], idx_q};
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end else if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          mirror_d[idx_q] = tgt_q[idx_q];
          cnt_d           = HOLD_LD;
          state_d         = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    nbitw1_d = (state_d != S_STROBE);
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 3'd0;
      tgt_q    <= 8'h00;
      force_q  <= 1'b0;
      mirror_q <= 8'h00;
      addr_q   <= 4'h0;
      nbitw1_q <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tgt_q    <= tgt_d;
      force_q  <= force_d;
      mirror_q <= mirror_d;
      addr_q   <= addr_d;
      nbitw1_q <= nbitw1_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign BUSY         = busy_q;
  assign ACK          = ack_q;
  assign M68K_ADDR    = addr_q;
  assign nBITW1       = nbitw1_q;
  assign LATCH_MIRROR = mirror_q;

endmodule

// File: tb/tb_syslatch_seq.sv
// Directed and random checks of syslatch_seq with three timing configurations,
// the outputs driving a bit-addressed latch model.
module tb_syslatch_seq;

  logic       clk;
  logic       rst_n [3];
  logic       req   [3];
  logic [7:0] tgt   [3];
  logic       frc   [3];
  logic       busy  [3];
  logic       ack   [3];
  logic [4:1] addr  [3];
  logic       nb    [3];
  logic [7:0] mir   [3];

  int ST [3] = '{2, 1, 15};
  int PP [3] = '{4, 3, 45};

  int errors = 0;
  int checks = 0;

  syslatch_seq u0 (
    .CLK_24M(clk), .nRESET(rst_n[0]), .REQ(req[0]), .TARGET(tgt[0]), .FORCE(frc[0]),
    .BUSY(busy[0]), .ACK(ack[0]), .M68K_ADDR(addr[0]), .nBITW1(nb[0]), .LATCH_MIRROR(mir[0]));
  syslatch_seq #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u1 (
    .CLK_24M(clk), .nRESET(rst_n[1]), .REQ(req[1]), .TARGET(tgt[1]), .FORCE(frc[1]),
    .BUSY(busy[1]), .ACK(ack[1]), .M68K_ADDR(addr[1]), .nBITW1(nb[1]), .LATCH_MIRROR(mir[1]));
  syslatch_seq #(.SETUP_CYCLES(15), .STROBE_CYCLES(15), .HOLD_CYCLES(15)) u2 (
    .CLK_24M(clk), .nRESET(rst_n[2]), .REQ(req[2]), .TARGET(tgt[2]), .FORCE(frc[2]),
    .BUSY(busy[2]), .ACK(ack[2]), .M68K_ADDR(addr[2]), .nBITW1(nb[2]), .LATCH_MIRROR(mir[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch model plus strobe monitor, sampled on the falling edge.
  logic [7:0] lm      [3] = '{8'h00, 8'h00, 8'h00};
  logic       prev_nb [3] = '{1'b1, 1'b1, 1'b1};
  int         strobes [3] = '{0, 0, 0};
  int         wid     [3] = '{0, 0, 0};
  int         wbad    [3] = '{0, 0, 0};
  logic [3:0] aq0 [$];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n[d]) begin
        lm[d] = 8'h00;
      end else begin
        if (nb[d] == 1'b0) lm[d][addr[d][3:1]] = addr[d][4];
        if (prev_nb[d] && !nb[d]) begin
          strobes[d]++;
          wid[d] = 1;
          if (d == 0) aq0.push_back(addr[d]);
        end else if (!nb[d]) begin
          wid[d]++;
        end
        if (!prev_nb[d] && nb[d] && wid[d] != ST[d]) wbad[d]++;
      end
      prev_nb[d] = nb[d];
    end
  end

  task automatic drive_req(input int d, input logic [7:0] t, input logic f);
    #1;
    req[d] = 1'b1; tgt[d] = t; frc[d] = f;
  endtask

  // Waits for BUSY then counts cycles up to and including ACK.
  task automatic wait_txn(input int d, input bit drop_req, input bit disturb,
                          output int acyc, output int bbad);
    int w, n;
    acyc = -1; bbad = 0; w = 0; n = 0;
    do begin @(negedge clk); w++; end while (busy[d] !== 1'b1 && w < 20);
    if (busy[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL busy_start dut%0d: BUSY=%b never rose, required 1", d, busy[d]);
      return;
    end
    n = 1;
    if (drop_req) begin #1; req[d] = 1'b0; end
    while (ack[d] !== 1'b1 && n < 3000) begin
      if (disturb) begin
        #1;
        if (n == 4) begin req[d] = 1'b1; tgt[d] = 8'h00; frc[d] = 1'b1; end
        else if (n == 10) req[d] = 1'b0;
        else if (n == 20) req[d] = 1'b1;
        else if (n == 30) begin req[d] = 1'b0; frc[d] = 1'b0; end
      end
      @(negedge clk); n++;
      if (busy[d] !== 1'b1) bbad++;
    end
    if (ack[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d: no ACK after %0d cycles", d, n);
      return;
    end
    acyc = n;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin rst_n[d] = 1'b0; req[d] = 1'b0; tgt[d] = 8'h00; frc[d] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (nb[0] !== 1'b1) begin errors++; $display("FAIL rst_nbitw1: got %b want 1", nb[0]); end
    checks++; if (addr[0] !== 4'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack[0]); end
    for (int d = 0; d < 3; d++) begin
      checks++; if (mir[d] !== 8'h00) begin errors++; $display("FAIL rst_mirror dut%0d: got %h want 00", d, mir[d]); end
    end
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
  endtask

  task automatic test_reset_mid_strobe();
    int w;
    drive_req(0, 8'h01, 1'b0);
    @(negedge clk); #1; req[0] = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (nb[0] !== 1'b0 && w < 30);
    checks++; if (nb[0] !== 1'b0) begin errors++; $display("FAIL mid_strobe_seen: nBITW1=%b want 0", nb[0]); end
    #1; rst_n[0] = 1'b0;
    @(negedge clk);
    checks++; if (nb[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_nbitw1: got %b want 1", nb[0]); end
    checks++; if (mir[0] !== 8'h00) begin errors++; $display("FAIL mid_rst_mirror: got %h want 00", mir[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy[0]); end
    checks++; if (addr[0] !== 4'h0) begin errors++; $display("FAIL mid_rst_addr: got %h want 0", addr[0]); end
    #1; rst_n[0] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_bit();
    int ac, bb, s0, w0, q0;
    s0 = strobes[0]; w0 = wbad[0]; q0 = aq0.size();
    drive_req(0, 8'h01, 1'b0);
    wait_txn(0, 1'b1, 1'b0, ac, bb);
    checks++; if (ac != 13) begin errors++; $display("FAIL single_ack_cycle: got %0d want 13", ac); end
    checks++; if (strobes[0] - s0 != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobes[0] - s0); end
    checks++; if (aq0.size() > q0 && aq0[q0] !== 4'b1000) begin errors++; $display("FAIL single_addr: got %b want 1000", aq0[q0]); end
    checks++; if (wbad[0] != w0) begin errors++; $display("FAIL single_width: %0d pulses not 2 cycles wide", wbad[0] - w0); end
    checks++; if (mir[0] !== 8'h01) begin errors++; $display("FAIL single_mirror: got %h want 01", mir[0]); end
    checks++; if (bb != 0) begin errors++; $display("FAIL single_busy: %0d cycles low, want 0", bb); end
  endtask

  task automatic test_force();
    int ac, bb, s0, q0;
    logic [3:0] ea [8] = '{4'b1000, 4'b0001, 4'b1010, 4'b0011, 4'b0100, 4'b1101, 4'b0110, 4'b1111};
    drive_req(0, 8'hA5, 1'b0);
    wait_txn(0, 1'b1, 1'b0, ac, bb);
    checks++; if (mir[0] !== 8'hA5) begin errors++; $display("FAIL prep_a5_mirror: got %h want a5", mir[0]); end
    s0 = strobes[0];
    drive_req(0, 8'hA5, 1'b0);
    wait_txn(0, 1'b1, 1'b0, ac, bb);
    checks++; if (ac != 9) begin errors++; $display("FAIL nochange_ack_cycle: got %0d want 9", ac); end
    checks++; if (strobes[0] != s0) begin errors++; $display("FAIL nochange_strobes: got %0d want 0", strobes[0] - s0); end
    s0 = strobes[0]; q0 = aq0.size();
    drive_req(0, 8'hA5, 1'b1);
    wait_txn(0, 1'b1, 1'b0, ac, bb);
    checks++; if (ac != 41) begin errors++; $display("FAIL force_ack_cycle: got %0d want 41", ac); end
    checks++; if (strobes[0] - s0 != 8) begin errors++; $display("FAIL force_strobes: got %0d want 8", strobes[0] - s0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (aq0.size() <= q0 + i || aq0[q0 + i] !== ea[i]) begin
        errors++; $display("FAIL force_addr%0d: got %b want %b", i, (aq0.size() > q0 + i) ? aq0[q0 + i] : 4'hx, ea[i]);
      end
    end
    checks++; if (mir[0] !== 8'hA5) begin errors++; $display("FAIL force_mirror: got %h want a5", mir[0]); end
  endtask

  task automatic test_full_ignore_inputs();
    int ac, bb, s0, q0;
    logic [3:0] want;
    drive_req(0, 8'h00, 1'b0);
    wait_txn(0, 1'b1, 1'b0, ac, bb);
    checks++; if (mir[0] !== 8'h00) begin errors++; $display("FAIL prep_00_mirror: got %h want 00", mir[0]); end
    s0 = strobes[0]; q0 = aq0.size();
    drive_req(0, 8'hFF, 1'b0);
    wait_txn(0, 1'b1, 1'b1, ac, bb);
    checks++; if (ac != 41) begin errors++; $display("FAIL full_ack_cycle: got %0d want 41", ac); end
    checks++; if (bb != 0) begin errors++; $display("FAIL full_busy: %0d cycles low, want 0", bb); end
    checks++; if (strobes[0] - s0 != 8) begin errors++; $display("FAIL full_strobes: got %0d want 8", strobes[0] - s0); end
    for (int i = 0; i < 8; i++) begin
      want = 4'b1000 | 4'(i);
      checks++;
      if (aq0.size() <= q0 + i || aq0[q0 + i] !== want) begin
        errors++; $display("FAIL full_addr%0d: got %b want %b", i, (aq0.size() > q0 + i) ? aq0[q0 + i] : 4'hx, want);
      end
    end
    checks++; if (mir[0] !== 8'hFF) begin errors++; $display("FAIL full_mirror: got %h want ff", mir[0]); end
    @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b want 0", busy[0]); end
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL full_ack_pulse: got %b want 0", ack[0]); end
    checks++; if (lm[0] !== mir[0]) begin errors++; $display("FAIL full_latch_model: model %h mirror %h", lm[0], mir[0]); end
  endtask

  // Random targets; held=1 keeps REQ high so transactions run back to back.
  task automatic test_random(input int d, input int cnt, input bit held, inout logic [7:0] em);
    int ac, bb, s0, w0, nexp;
    logic [7:0] t;
    logic f;
    for (int k = 0; k < cnt; k++) begin
      t = 8'($urandom);
      f = ($urandom_range(0, 3) == 0);
      nexp = f ? 8 : $countones(em ^ t);
      s0 = strobes[d]; w0 = wbad[d];
      drive_req(d, t, f);
      wait_txn(d, !held, 1'b0, ac, bb);
      checks++; if (ac != 9 + nexp * PP[d]) begin errors++; $display("FAIL rnd_ack_cycle dut%0d: got %0d want %0d", d, ac, 9 + nexp * PP[d]); end
      checks++; if (strobes[d] - s0 != nexp) begin errors++; $display("FAIL rnd_strobes dut%0d: got %0d want %0d", d, strobes[d] - s0, nexp); end
      checks++; if (mir[d] !== t) begin errors++; $display("FAIL rnd_mirror dut%0d: got %h want %h", d, mir[d], t); end
      checks++; if (lm[d] !== mir[d]) begin errors++; $display("FAIL rnd_latch_model dut%0d: model %h mirror %h", d, lm[d], mir[d]); end
      checks++; if (wbad[d] != w0 || bb != 0) begin errors++; $display("FAIL rnd_shape dut%0d: width errs %0d busy gaps %0d, want 0", d, wbad[d] - w0, bb); end
      em = t;
    end
    #1; req[d] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] em1, em2;
    em1 = 8'h00; em2 = 8'h00;
    test_reset();
    test_reset_mid_strobe();
    test_single_bit();
    test_force();
    test_full_ignore_inputs();
    test_random(1, 10, 1'b1, em1);
    test_random(1, 4, 1'b0, em1);
    test_random(2, 6, 1'b1, em2);
    test_random(2, 3, 1'b0, em2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
